// File: rtl/icache_refill_unit.sv
// rtl/icache_refill_unit.sv - instruction-cache line refill engine (miss -> burst read -> line write)
//
// Optional feature macro: ICACHE_REFILL_PERF_CNT_EN (adds o_refill_cnt)
//
// Ports:
//   i_clk, i_arst          clock, asynchronous active-low reset
//   i_icache_miss          fetch-stage miss for the current PC
//   i_miss_addr            miss address (low 6 bits ignored, line aligned)
//   o_arvalid/i_arready    read-address handshake
//   o_araddr/arlen/arsize/arburst  burst descriptor (INCR, BEATS beats)
//   i_rvalid/o_rready      read-data handshake
//   i_rdata/i_rresp/i_rlast  beat payload, response, last-beat marker
//   o_instr_block          assembled cache line
//   o_instr_we             one-cycle line write strobe
//   o_stall_fetch          fetch stall request
//   o_bus_error            sticky refill error flag
//   o_refill_cnt           saturating count of completed refills (macro only)

module icache_refill_unit #(
    parameter int ADDR_WIDTH  = 64,
    parameter int BLOCK_WIDTH = 512,
    parameter int DATA_WIDTH  = 64
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_icache_miss,
    input  logic [ADDR_WIDTH-1:0]  i_miss_addr,
    output logic                   o_arvalid,
    input  logic                   i_arready,
    output logic [ADDR_WIDTH-1:0]  o_araddr,
    output logic [7:0]             o_arlen,
    output logic [2:0]             o_arsize,
    output logic [1:0]             o_arburst,
    input  logic                   i_rvalid,
    output logic                   o_rready,
    input  logic [DATA_WIDTH-1:0]  i_rdata,
    input  logic [1:0]             i_rresp,
    input  logic                   i_rlast,
    output logic [BLOCK_WIDTH-1:0] o_instr_block,
    output logic                   o_instr_we,
    output logic                   o_stall_fetch,
    output logic                   o_bus_error
`ifdef ICACHE_REFILL_PERF_CNT_EN
    ,
    output logic [31:0]            o_refill_cnt
`endif
);

    localparam int BEATS = BLOCK_WIDTH / DATA_WIDTH;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ADDR  = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  burst_err;

    logic beat_ok;
    logic beat_err;
    logic err_now;

    // Low address bits are replaced by the line offset of zero.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^i_miss_addr[5:0];

    assign o_arvalid     = (state == ADDR);
    assign o_araddr      = addr_q;
    assign o_rready      = (state == DATA);
    assign o_instr_we    = (state == WRITE);
    assign o_stall_fetch = i_icache_miss | (state != IDLE);

    assign o_arlen   = 8'(BEATS - 1);
    assign o_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign o_arburst = 2'b01;

    assign beat_ok  = i_rvalid & o_rready;
    assign beat_err = (i_rresp != 2'b00);
    // Error status including the beat being accepted this cycle.
    assign err_now  = burst_err | beat_err;

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state         <= IDLE;
            cnt           <= '0;
            addr_q        <= '0;
            burst_err     <= 1'b0;
            o_instr_block <= '0;
            o_bus_error   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_icache_miss) begin
                        addr_q    <= {i_miss_addr[ADDR_WIDTH-1:6], 6'b0};
                        cnt       <= '0;
                        burst_err <= 1'b0;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (i_arready) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (beat_ok) begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (cnt == CW'(b)) begin
                                o_instr_block[b*DATA_WIDTH +: DATA_WIDTH] <= i_rdata;
                            end
                        end
                        cnt <= (cnt == LAST_BEAT) ? '0 : cnt + 1'b1;
                        if (beat_err) begin
                            burst_err <= 1'b1;
                        end
                        if (i_rlast) begin
                            if ((cnt == LAST_BEAT) && !err_now) begin
                                state <= WRITE;
                            end else begin
                                o_bus_error <= 1'b1;
                                state       <= IDLE;
                            end
                        end else if (cnt == LAST_BEAT) begin
                            // Overlong burst: flag now, keep draining until
                            // the slave finally signals last; the line is
                            // never written because burst_err is now set.
                            o_bus_error <= 1'b1;
                            burst_err   <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ICACHE_REFILL_PERF_CNT_EN
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            o_refill_cnt <= '0;
        end else if (o_instr_we && (o_refill_cnt != 32'hFFFF_FFFF)) begin
            o_refill_cnt <= o_refill_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_refill_unit.sv
// tb/tb_icache_refill_unit.sv - directed scoreboard bench for icache_refill_unit

module tb_icache_refill_unit;

    logic         clk;
    logic         arst;
    logic         miss;
    logic [63:0]  miss_addr;
    logic         arvalid;
    logic         arready;
    logic [63:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         rvalid;
    logic         rready;
    logic [63:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic [511:0] block;
    logic         we;
    logic         stall;
    logic         bus_err;
`ifdef ICACHE_REFILL_PERF_CNT_EN
    logic [31:0]  refill_cnt;
    int           clean_cnt = 0;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int we_cnt = 0;
    int last_we_cyc = 0;
    logic prev_we = 1'b0;
    logic [511:0] exp_blk;
    logic [511:0] sb[$];

    icache_refill_unit dut (
        .i_clk         (clk),
        .i_arst        (arst),
        .i_icache_miss (miss),
        .i_miss_addr   (miss_addr),
        .o_arvalid     (arvalid),
        .i_arready     (arready),
        .o_araddr      (araddr),
        .o_arlen       (arlen),
        .o_arsize      (arsize),
        .o_arburst     (arburst),
        .i_rvalid      (rvalid),
        .o_rready      (rready),
        .i_rdata       (rdata),
        .i_rresp       (rresp),
        .i_rlast       (rlast),
        .o_instr_block (block),
        .o_instr_we    (we),
        .o_stall_fetch (stall),
        .o_bus_error   (bus_err)
`ifdef ICACHE_REFILL_PERF_CNT_EN
        ,
        .o_refill_cnt  (refill_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Write-strobe monitor: every pulse must match the oldest expected line.
    always @(negedge clk) begin
        if (arst && we) begin
            we_cnt++;
            last_we_cyc = cyc;
            chk("we_single_cycle", prev_we, 1'b0);
            chk("sb_nonempty", (sb.size() > 0), 1'b1);
            if (sb.size() > 0) begin
                exp_blk = sb.pop_front();
                chk("block", block, exp_blk);
            end
        end
        prev_we = arst & we;
    end

    task automatic pulse_reset();
        @(posedge clk); #1;
        arst = 1'b0;
        repeat (2) @(posedge clk);
        #1 arst = 1'b1;
`ifdef ICACHE_REFILL_PERF_CNT_EN
        clean_cnt = 0;
`endif
        @(posedge clk); #1;
    endtask

    // One refill: rlast on beat nbeats-1, err_beat gets SLVERR, rst_beat
    // asserts reset just before that beat. Called at #1 after a rising edge.
    task automatic refill(input logic [63:0] addr, input logic [31:0] seed,
                          input int arwait, input int gap, input int nbeats,
                          input int err_beat, input int rst_beat,
                          input bit good, input bit chk_lat);
        logic [511:0] exp;
        logic [63:0]  exp_addr;
        int           miss_cyc;
        int           we0;
        exp_addr = {addr[63:6], 6'b0};
        exp = '0;
        for (int k = 0; k < 8; k++) exp[k*64 +: 64] = {seed, 32'(k)};
        if (good) sb.push_back(exp);
        we0 = we_cnt;

        miss = 1'b1; miss_addr = addr; miss_cyc = cyc;
        @(posedge clk); #1;
        // Dropping the miss and scrambling the address must not disturb the refill.
        miss = 1'b0; miss_addr = ~addr;
        chk("stall_addr", stall, 1'b1);
        for (int i = 0; i < arwait; i++) begin
            chk("arvalid_wait", arvalid, 1'b1);
            chk("araddr_wait", araddr, exp_addr);
            @(posedge clk); #1;
        end
        chk("arvalid", arvalid, 1'b1);
        chk("araddr", araddr, exp_addr);
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        chk("arvalid_after_hs", arvalid, 1'b0);

        for (int b = 0; b < nbeats; b++) begin
            if (b == rst_beat) begin
                rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
                #3 arst = 1'b0;
                #1;
                chk("rst_arvalid", arvalid, 1'b0);
                chk("rst_rready", rready, 1'b0);
                chk("rst_we", we, 1'b0);
                chk("rst_stall", stall, 1'b0);
                chk("rst_block", block, 512'd0);
                chk("rst_bus_err", bus_err, 1'b0);
                repeat (2) @(posedge clk);
                #1 arst = 1'b1;
`ifdef ICACHE_REFILL_PERF_CNT_EN
                clean_cnt = 0;
`endif
                repeat (4) @(posedge clk);
                #1;
                chk("rst_no_we", we_cnt - we0, 0);
                return;
            end
            for (int g = 0; g < gap; g++) begin
                rvalid = 1'b0;
                @(posedge clk); #1;
                chk("rready_gap", rready, 1'b1);
            end
            rvalid = 1'b1;
            rdata  = {seed, 32'(b)};
            rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            rlast  = (b == nbeats - 1);
            chk("rready_beat", rready, 1'b1);
            chk("arvalid_in_data", arvalid, 1'b0);
            @(posedge clk); #1;
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;

        if (good) begin
            chk("we_in_write", we, 1'b1);
            chk("stall_in_write", stall, 1'b1);
            @(posedge clk); #1;
            chk("we_after_write", we, 1'b0);
            chk("stall_after_write", stall, 1'b0);
`ifdef ICACHE_REFILL_PERF_CNT_EN
            clean_cnt++;
`endif
        end else begin
            chk("we_bad", we, 1'b0);
            chk("stall_bad", stall, 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("we_count", we_cnt - we0, good ? 1 : 0);
        // Write strobe lands in the 11th cycle counting the miss cycle as the first.
        if (chk_lat) chk("latency", last_we_cyc - miss_cyc, 10);
        chk("rready_idle", rready, 1'b0);
        chk("arvalid_idle", arvalid, 1'b0);
    endtask

    initial begin
        arst = 1'b0; miss = 1'b0; miss_addr = '0; arready = 1'b0;
        rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
        #1;
        chk("reset_stall", stall, 1'b0);
        chk("reset_arvalid", arvalid, 1'b0);
        chk("reset_block", block, 512'd0);
        chk("reset_bus_err", bus_err, 1'b0);
        chk("reset_araddr", araddr, 64'd0);
        repeat (2) @(posedge clk);
        #1 arst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_arvalid", arvalid, 1'b0);
        chk("post_rst_rready", rready, 1'b0);
        chk("post_rst_we", we, 1'b0);
        chk("post_rst_stall", stall, 1'b0);
        chk("arlen", arlen, 8'd7);
        chk("arsize", arsize, 3'd3);
        chk("arburst", arburst, 2'b01);

        // Basic refill: word k = k, line address 0x1200
        refill(64'h0000_1234, 32'h0, 0, 0, 8, -1, -1, 1'b1, 1'b1);
        chk("araddr_basic", araddr, 64'h0000_1200);
        chk("bus_err_clean", bus_err, 1'b0);

        // Slow slave: 5 cycles of arready wait, 2-cycle rvalid gaps
        refill(64'hDEAD_BEEF_0000_5678, 32'h1, 5, 2, 8, -1, -1, 1'b1, 1'b0);
        chk("bus_err_slow", bus_err, 1'b0);

        // SLVERR on beat 3, then a clean refill with the flag still set
        refill(64'h0000_4000, 32'h2, 0, 0, 8, 3, -1, 1'b0, 1'b0);
        chk("bus_err_resp", bus_err, 1'b1);
        refill(64'h0000_4040, 32'h3, 0, 0, 8, -1, -1, 1'b1, 1'b0);
        chk("bus_err_sticky", bus_err, 1'b1);

        // Reset before beat 4, then a normal refill
        refill(64'h0000_8000, 32'h4, 0, 0, 8, -1, 4, 1'b0, 1'b0);
        refill(64'h0000_8000, 32'h5, 0, 0, 8, -1, -1, 1'b1, 1'b0);
        chk("bus_err_after_rst", bus_err, 1'b0);

        // Early rlast on beat 5
        refill(64'h0000_9000, 32'h6, 0, 0, 6, -1, -1, 1'b0, 1'b0);
        chk("bus_err_short", bus_err, 1'b1);

        // Missing rlast at beat 7: drain until beat 9
        pulse_reset();
        chk("bus_err_cleared", bus_err, 1'b0);
        refill(64'h0000_A000, 32'h7, 0, 0, 10, -1, -1, 1'b0, 1'b0);
        chk("bus_err_long", bus_err, 1'b1);

        refill(64'h0000_B000, 32'h8, 1, 1, 8, -1, -1, 1'b1, 1'b0);
        chk("bus_err_final", bus_err, 1'b1);
        chk("sb_drained", sb.size(), 0);
`ifdef ICACHE_REFILL_PERF_CNT_EN
        chk("refill_cnt", refill_cnt, 32'(clean_cnt));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
